fooart_serial_phy: RTL and testbench

//  8N1 serial line PHY for the fooart UART core. Deserialises i_rxd into bytes held in
//  an RX FIFO, presented on the fooart byte interface (data/available/strobe). Serialises

---
 rtl/fooart_serial_phy.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_fooart_serial_phy.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fooart_serial_phy.sv
// fooart_serial_phy: 8N1 serial PHY. RX deserialiser feeding an RX FIFO (first-word-fall-through)
// and a TX FIFO feeding a TX serialiser. Both run off a shared 16x oversample tick.
module fooart_serial_phy #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rxd,
  output logic       o_txd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_available,
  input  logic       i_rx_stb,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_stb,
  output logic       o_tx_full,
  output logic       o_tx_busy,
  output logic       o_rx_overrun,
  output logic       o_frame_err
);

  localparam int unsigned TickW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RxAw  = $clog2(RX_DEPTH);
  localparam int unsigned TxAw  = $clog2(TX_DEPTH);
  localparam logic [TickW-1:0] TickLast = TickW'(CLK_DIV - 1);
  localparam logic [TickW-1:0] TickOne  = TickW'(1);
  localparam logic [RxAw:0]    RxOne    = (RxAw + 1)'(1);
  localparam logic [TxAw:0]    TxOne    = (TxAw + 1)'(1);

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxBreak} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  assign tick = (tick_cnt_q == TickLast);

  // Free-running divider, wraps after CLK_DIV-1.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickOne;
  end

  // Tick counter register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) tick_cnt_q <= '0;
    else            tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rxs;
  assign rxs = sync_q[1];

  // Two-flop synchroniser, reset to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], i_rxd};
  end

  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_ph_q, rx_ph_d;
  logic [2:0] rx_n_q, rx_n_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       rx_push, rx_ferr;

  // RX next-state: all decisions taken on ticks using the synchronised line.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_ph_d    = rx_ph_q;
    rx_n_d     = rx_n_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    if (tick) begin
      case (rx_state_q)
        RxIdle: begin
          if (!rxs) begin
            rx_state_d = RxStart;
            rx_ph_d    = 4'd0;
          end
        end
        RxStart: begin
          // Re-check the line at the start-bit midpoint to reject glitches.
          if (rx_ph_q == 4'd7) begin
            if (rxs) begin
              rx_state_d = RxIdle;
            end else begin
              rx_state_d = RxData;
              rx_ph_d    = 4'd0;
              rx_n_d     = 3'd0;
            end
          end else begin
            rx_ph_d = rx_ph_q + 4'd1;
          end
        end
        RxData: begin
          if (rx_ph_q == 4'd15) begin
            rx_sh_d = {rxs, rx_sh_q[7:1]};
            rx_ph_d = 4'd0;
            if (rx_n_q == 3'd7) rx_state_d = RxStop;
            else                rx_n_d     = rx_n_q + 3'd1;
          end else begin
            rx_ph_d = rx_ph_q + 4'd1;
          end
        end
        RxStop: begin
          if (rx_ph_q == 4'd15) begin
            if (rxs) begin
              rx_push    = 1'b1;
              rx_state_d = RxIdle;
            end else begin
              rx_ferr    = 1'b1;
              rx_state_d = RxBreak;
            end
          end else begin
            rx_ph_d = rx_ph_q + 4'd1;
          end
        end
        RxBreak: begin
          if (rxs) rx_state_d = RxIdle;
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  // RX FSM registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_state_q <= RxIdle;
      rx_ph_q    <= '0;
      rx_n_q     <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_ph_q    <= rx_ph_d;
      rx_n_q     <= rx_n_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO (extra pointer bit distinguishes full from empty)
  // ---------------------------------------------------------------------------
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [RxAw:0] rx_wp_q, rx_rp_q;
  logic        rx_empty, rx_full, rx_pop, rx_wr, rx_ovr;

  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[RxAw] != rx_rp_q[RxAw]) &&
                    (rx_wp_q[RxAw-1:0] == rx_rp_q[RxAw-1:0]);
  assign rx_pop   = i_rx_stb && !rx_empty;
  // A same-cycle pop frees the slot, so a push while full still lands.
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign rx_ovr   = rx_push && rx_full && !rx_pop;

  assign o_rx_available = !rx_empty;
  assign o_rx_data      = rx_empty ? 8'h00 : rx_mem[rx_rp_q[RxAw-1:0]];

  // RX FIFO storage.
  always_ff @(posedge i_clk) begin
    if (rx_wr) rx_mem[rx_wp_q[RxAw-1:0]] <= rx_sh_q;
  end

  // RX FIFO pointers and registered error pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_wp_q      <= '0;
      rx_rp_q      <= '0;
      o_rx_overrun <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp_q <= rx_wp_q + RxOne;
      if (rx_pop) rx_rp_q <= rx_rp_q + RxOne;
      o_rx_overrun <= rx_ovr;
      o_frame_err  <= rx_ferr;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [TxAw:0] tx_wp_q, tx_rp_q;
  logic        tx_empty, tx_full, tx_pop, tx_wr;
  logic [7:0]  tx_head;

  assign tx_empty  = (tx_wp_q == tx_rp_q);
  assign tx_full   = (tx_wp_q[TxAw] != tx_rp_q[TxAw]) &&
                     (tx_wp_q[TxAw-1:0] == tx_rp_q[TxAw-1:0]);
  assign tx_wr     = i_tx_stb && (!tx_full || tx_pop);
  assign tx_head   = tx_mem[tx_rp_q[TxAw-1:0]];
  assign o_tx_full = tx_full;

  // TX FIFO storage.
  always_ff @(posedge i_clk) begin
    if (tx_wr) tx_mem[tx_wp_q[TxAw-1:0]] <= i_tx_data;
  end

  // TX FIFO pointers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_wr)  tx_wp_q <= tx_wp_q + TxOne;
      if (tx_pop) tx_rp_q <= tx_rp_q + TxOne;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM: every bit held for 16 ticks, txd driven from a register
  // ---------------------------------------------------------------------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_ph_q, tx_ph_d;
  logic [2:0] tx_n_q, tx_n_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic       txd_q, txd_d;

  // TX next-state; a pending byte at the end of a stop bit starts immediately.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_ph_d    = tx_ph_q;
    tx_n_d     = tx_n_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    if (tick) begin
      case (tx_state_q)
        TxIdle: begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sh_d    = tx_head;
            txd_d      = 1'b0;
            tx_ph_d    = 4'd0;
            tx_state_d = TxStart;
          end
        end
        TxStart: begin
          if (tx_ph_q == 4'd15) begin
            tx_state_d = TxData;
            tx_ph_d    = 4'd0;
            tx_n_d     = 3'd0;
            txd_d      = tx_sh_q[0];
          end else begin
            tx_ph_d = tx_ph_q + 4'd1;
          end
        end
        TxData: begin
          if (tx_ph_q == 4'd15) begin
            tx_ph_d = 4'd0;
            if (tx_n_q == 3'd7) begin
              tx_state_d = TxStop;
              txd_d      = 1'b1;
            end else begin
              tx_n_d  = tx_n_q + 3'd1;
              tx_sh_d = tx_sh_q >> 1;
              txd_d   = tx_sh_q[1];
            end
          end else begin
            tx_ph_d = tx_ph_q + 4'd1;
          end
        end
        TxStop: begin
          if (tx_ph_q == 4'd15) begin
            tx_ph_d = 4'd0;
            if (!tx_empty) begin
              tx_pop     = 1'b1;
              tx_sh_d    = tx_head;
              txd_d      = 1'b0;
              tx_state_d = TxStart;
            end else begin
              tx_state_d = TxIdle;
            end
          end else begin
            tx_ph_d = tx_ph_q + 4'd1;
          end
        end
        default: tx_state_d = TxIdle;
      endcase
    end
  end

  // TX FSM registers; txd resets to the idle-high line level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q <= TxIdle;
      tx_ph_q    <= '0;
      tx_n_q     <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_ph_q    <= tx_ph_d;
      tx_n_q     <= tx_n_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
    end
  end

  assign o_txd     = txd_q;
  assign o_tx_busy = (tx_state_q != TxIdle) || !tx_empty;

endmodule

// File: tb/tb_fooart_serial_phy.sv
// Directed bench for fooart_serial_phy with CLK_DIV=4 (64 clocks per bit).
module tb_fooart_serial_phy;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_stb = 1'b0;
  logic       tx_stb = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd, avail, tx_full, busy, ovr, ferr;
  logic [7:0] rx_data;
  logic       rxd;

  assign rxd = loop ? txd : rxd_drv;

  fooart_serial_phy #(
    .CLK_DIV (4),
    .RX_DEPTH(8),
    .TX_DEPTH(8)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_rxd         (rxd),
    .o_txd         (txd),
    .o_rx_data     (rx_data),
    .o_rx_available(avail),
    .i_rx_stb      (rx_stb),
    .i_tx_data     (tx_data),
    .i_tx_stb      (tx_stb),
    .o_tx_full     (tx_full),
    .o_tx_busy     (busy),
    .o_rx_overrun  (ovr),
    .o_frame_err   (ferr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  always @(negedge clk) begin
    if (ovr)  ovr_cnt++;
    if (ferr) ferr_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 'h%0h want 'h%0h", tag, obs, exp);
  endtask

  task automatic rx_bit(input logic v, input int clks);
    rxd_drv = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b);
    rx_bit(1'b0, 64);
    for (int i = 0; i < 8; i++) rx_bit(b[i], 64);
    rx_bit(1'b1, 64);
  endtask

  task automatic wait_avail(input int budget, output logic ok);
    ok = avail;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = avail;
    end
  endtask

  task automatic pop(output logic [7:0] d);
    d = rx_data;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_stb  = 1'b1;
    @(negedge clk);
    tx_stb  = 1'b0;
  endtask

  initial begin
    logic       ok;
    logic [7:0] d;
    logic [7:0] pat;
    int         o0, f0, w;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", int'(txd), 1);
    check("rst_avail", int'(avail), 0);
    check("rst_full", int'(tx_full), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_ferr", int'(ferr), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Receive 0x55 then pop
    send_frame(8'h55);
    wait_avail(128, ok);
    check("rx55_avail", int'(ok), 1);
    check("rx55_data", int'(rx_data), 'h55);
    pop(d);
    check("rx55_popped", int'(avail), 0);

    // Transmit 0xA3
    push(8'hA3);
    check("txa3_busy", int'(busy), 1);
    ok = txd;
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge clk);
      ok = txd;
    end
    check("txa3_start_seen", int'(ok), 0);
    w = 0;
    while (txd == 1'b0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("txa3_start_width", w, 64);
    repeat (32) @(negedge clk);
    pat = 8'hA3;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("txa3_bit%0d", i), int'(txd), int'(pat[i]));
      repeat (64) @(negedge clk);
    end
    check("txa3_stop", int'(txd), 1);
    check("txa3_busy_stop", int'(busy), 1);
    repeat (48) @(negedge clk);
    check("txa3_idle_busy", int'(busy), 0);
    check("txa3_idle_txd", int'(txd), 1);

    // Nine bytes with no pops: the ninth overruns
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) send_frame(8'(i));
    repeat (64) @(negedge clk);
    check("ovr_none_at8", ovr_cnt - o0, 0);
    send_frame(8'h08);
    repeat (64) @(negedge clk);
    check("ovr_once", ovr_cnt - o0, 1);
    check("ovr_no_ferr", ferr_cnt - f0, 0);
    for (int i = 0; i < 8; i++) begin
      pop(d);
      check($sformatf("ovr_pop%0d", i), int'(d), i);
    end
    check("ovr_drained", int'(avail), 0);

    // Framing error with long break, then recovery
    f0 = ferr_cnt;
    pat = 8'h3C;
    rx_bit(1'b0, 64);
    for (int i = 0; i < 8; i++) rx_bit(pat[i], 64);
    rx_bit(1'b0, 128);
    rx_bit(1'b1, 128);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_push", int'(avail), 0);
    send_frame(8'h81);
    wait_avail(128, ok);
    check("ferr_recover_avail", int'(ok), 1);
    check("ferr_recover_data", int'(rx_data), 'h81);
    pop(d);

    // Short glitch on idle line
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    rx_bit(1'b0, 20);
    rx_bit(1'b1, 64 * 12);
    check("glitch_avail", int'(avail), 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_ovr", ovr_cnt - o0, 0);

    // Loopback of 8 bytes
    loop = 1'b1;
    for (int i = 0; i < 8; i++) push(8'hF0 + 8'(i));
    ok = busy;
    for (int i = 0; i < 8000 && ok; i++) begin
      @(negedge clk);
      ok = busy;
    end
    check("loop_tx_done", int'(ok), 0);
    repeat (200) @(negedge clk);
    loop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop(d);
      check($sformatf("loop_rx%0d", i), int'(d), 'hF0 + i);
    end
    check("loop_drained", int'(avail), 0);

    // Asynchronous reset mid-TX and mid-RX
    send_frame(8'h5A);
    wait_avail(128, ok);
    check("mid_pre_avail", int'(ok), 1);
    push(8'h00);
    rx_bit(1'b0, 64);
    rx_bit(1'b0, 64);
    rx_bit(1'b1, 64);
    check("mid_pre_txd", int'(txd), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd", int'(txd), 1);
    check("mid_rst_avail", int'(avail), 0);
    check("mid_rst_busy", int'(busy), 0);
    rxd_drv = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'hC3);
    wait_avail(128, ok);
    check("post_rst_avail", int'(ok), 1);
    check("post_rst_data", int'(rx_data), 'hC3);
    pop(d);
    check("post_rst_txd", int'(txd), 1);
    check("post_rst_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
